// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: control inputs, memory read port, IR strobes and status.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);

  localparam int unsigned SC_W = 3;

  // control / execute-stage side
  logic              start;
  logic [ADDR_W-1:0] pc_in;
  logic              halt;
  logic              exec_done;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_addr;

  // program memory side
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;

  // instruction register side and status
  logic [DATA_W-1:0] ir_data;
  logic              T1;
  logic              T2;
  logic [ADDR_W-1:0] pc;
  logic [SC_W-1:0]   sc;
  logic              busy;
  logic              halted;

  // sequencer view
  modport master (
    input  start, pc_in, halt, exec_done, branch_en, branch_addr, mem_data,
    output mem_addr, mem_rd, ir_data, T1, T2, pc, sc, busy, halted
  );

  // environment view (memory, IR, execute stage, controller)
  modport slave (
    output start, pc_in, halt, exec_done, branch_en, branch_addr, mem_data,
    input  mem_addr, mem_rd, ir_data, T1, T2, pc, sc, busy, halted
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch initiator: reads a word at PC, strobes T1/T2 into the IR,
// then waits for the execute stage before the next fetch. Owns the PC.
module fetch_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  fetch_sequencer_if.master   bus
);

  localparam int unsigned SC_W = 3;

  typedef enum logic [SC_W-1:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_READ  = 3'd2,
    S_SETUP = 3'd3,
    S_T1    = 3'd4,
    S_T2    = 3'd5,
    S_EXEC  = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic [DATA_W-1:0] r_ir_data;
  logic [DATA_W-1:0] w_ir_data_nxt;
  logic              r_t1;
  logic              r_t2;
  logic [SC_W-1:0]   r_sc;
  logic              r_busy;
  logic              r_halted;
  logic              w_halted_nxt;
  logic              r_halt_req;
  logic              w_halt_req_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, PC, IR and halt bookkeeping
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_data_nxt  = r_ir_data;
    w_halted_nxt   = r_halted;
    // halt is a level request that sticks until we actually stop
    w_halt_req_nxt = r_halt_req | (bus.halt & (r_state != S_IDLE));

    unique case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.halt) begin
          w_pc_nxt     = bus.pc_in;
          w_halted_nxt = 1'b0;
          w_state_nxt  = S_ADDR;
        end
      end
      S_ADDR: begin
        w_state_nxt = S_READ;
      end
      S_READ: begin
        w_ir_data_nxt = bus.mem_data;
        w_pc_nxt      = r_pc + ADDR_W'(1);
        w_state_nxt   = S_SETUP;
      end
      S_SETUP: begin
        w_state_nxt = S_T1;
      end
      S_T1: begin
        w_state_nxt = S_T2;
      end
      S_T2: begin
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          if (bus.branch_en) begin
            w_pc_nxt = bus.branch_addr;
          end
          if (r_halt_req) begin
            w_state_nxt    = S_IDLE;
            w_halted_nxt   = 1'b1;
            w_halt_req_nxt = 1'b0;
          end else begin
            w_state_nxt = S_ADDR;
          end
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_halt_req_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_ir_data  <= '0;
      r_t1       <= 1'b0;
      r_t2       <= 1'b0;
      r_sc       <= '0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_halt_req <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_mem_addr <= w_pc_nxt;
      r_mem_rd   <= (w_state_nxt == S_ADDR);
      r_ir_data  <= w_ir_data_nxt;
      r_t1       <= (w_state_nxt == S_T1);
      r_t2       <= (w_state_nxt == S_T2);
      r_sc       <= SC_W'(w_state_nxt);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_halted   <= w_halted_nxt;
      r_halt_req <= w_halt_req_nxt;
    end
  end

  assign bus.pc       = r_pc;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_rd   = r_mem_rd;
  assign bus.ir_data  = r_ir_data;
  assign bus.T1       = r_t1;
  assign bus.T2       = r_t2;
  assign bus.sc       = r_sc;
  assign bus.busy     = r_busy;
  assign bus.halted   = r_halted;

endmodule
